im_loader: RTL and testbench
============================

# im_loader

Instruction-memory loader for the single-cycle/pipelined CPU. It accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit words and writes them into instruction memory at consecutive word addresses starting at the text base `0x3000`. While loading, it holds the fetch path (PC write enable) off. It is the writing end of the IM interface that the fetch unit reads, replacing the simulation-only `$readmemh` preload with a runtime load path.

## Interface
- `BASE_ADDR`, default `32'h3000`: byte address of the first instruction word.
- `DEPTH`, default `4096`: IM capacity in words; the largest accepted word count.
- `clk` input, 1 bit: the single clock; all state updates on its rising edge.
- `res` input, 1 bit: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `start` input, 1 bit: begin a load; honoured only in IDLE, DONE and ERR.
- `in_valid` input, 1 bit: `in_byte` carries a valid byte.
- `in_byte` input, 8 bits: stream byte.
- `in_ready` output, 1 bit: the loader accepts a byte this cycle.
- `im_we` output, 1 bit: one-cycle IM write strobe.
- `im_addr` output, 32 bits: byte address of the write, word aligned.
- `im_wdata` output, 32 bits: write data.
- `cpu_hold` output, 1 bit: high means the CPU must not advance; drives PC write enable low.
- `done` output, 1 bit: the load completed and the checksum matched.
- `error` output, 1 bit: the load was rejected (length too large or checksum mismatch).
- `word_cnt` output, 13 bits: number of words written in the current or last load.

## Operation
- Stream format, all fields big-endian:
  - LEN_HI, LEN_LO: 16-bit word count N.
  - 4·N data bytes.
  - One checksum byte, equal to the XOR of all data bytes. The length bytes are excluded from the checksum.
- A byte transfers on a rising edge where `in_valid & in_ready` is high. `in_byte` may change freely when no transfer occurs.
- FSM states and transitions:
  - IDLE: `start` → S_LENH.
  - S_LENH: on transfer, latch the high length byte → S_LENL.
  - S_LENL: on transfer, latch the low length byte.
    - N > DEPTH → ERR.
    - N == 0 → S_CSUM.
    - Otherwise → S_DATA.
  - S_DATA: shift each byte into the word assembly register, MSB first; the first byte lands in [31:24].
    - On the 4th byte, register the write: `im_wdata` = assembled word, `im_addr` = BASE_ADDR + 4·`word_cnt`, `im_we` = 1 for exactly the next cycle. `word_cnt` increments with the strobe.
    - After the N-th word's 4th byte → S_CSUM.
  - S_CSUM: on transfer, compare the byte against the running XOR. Match → DONE; mismatch → ERR.
  - DONE: `done` = 1, `cpu_hold` = 0. `start` → S_LENH.
  - ERR: `error` = 1, `cpu_hold` = 1. `start` → S_LENH.
- `in_ready` = 1 exactly in S_LENH, S_LENL, S_DATA and S_CSUM.
- `in_ready` is combinational from the state only; it never depends on `in_valid`.
- On `start` from DONE or ERR, the following are cleared on entry to S_LENH: `done`, `error`, `word_cnt`, the running XOR and the byte index. `cpu_hold` returns to 1.
- Words already written before an ERR stay in IM. They are not rolled back.
- `im_addr` arithmetic is 32-bit. The maximum address is BASE_ADDR + 4·(DEPTH−1), i.e. `0x6FFC` with defaults. The address never wraps because N ≤ DEPTH is enforced.
- `start` in any state other than IDLE, DONE or ERR is ignored.

## Timing
- Reset, applied while `res` = 0 at a rising edge:
  - State = IDLE; `cpu_hold` = 1; `in_ready` = 0.
  - `im_we` = 0; `im_addr` = 0; `im_wdata` = 0.
  - `done` = 0; `error` = 0; `word_cnt` = 0.
- Reset mid-load is honoured on the same edge: the load is aborted, and no `im_we` issues on the following cycle even if a 4th byte was presented.
- Throughput: one byte per cycle. Back-to-back `in_valid` sustains one word per 4 cycles.
- Write latency: `im_we` is asserted in the cycle after the edge that accepted the word's 4th byte.
- A transfer in the same cycle as an `im_we` pulse is legal; the next word assembles independently.
- Outputs `done` and `error` change on the edge after the checksum byte transfer. `cpu_hold` falls on that same edge.
- `word_cnt` shows the incremented value in the same cycle that `im_we` is high.

## Test plan
- Reset, then `start`; stream 00 01 24 08 00 05 and checksum 29 (0x24^0x08^0x00^0x05) → one `im_we` with `im_addr` = 0x3000 and `im_wdata` = 0x24080005, then `done` = 1, `cpu_hold` = 0, `word_cnt` = 1.
- N = 3 words streamed back-to-back with `in_valid` held high → `im_we` pulses at cycles 4, 8 and 12 after the first data byte edge, with addresses 0x3000/0x3004/0x3008. `in_ready` stays high throughout; then `done`.
- Same stream with `in_valid` toggling every other cycle → identical writes and data; only the timing stretches; no byte is lost or duplicated.
- Length 0x1001 (4097) → ERR after LEN_LO, `error` = 1, `cpu_hold` = 1, no `im_we`. Length 0 with checksum 00 → DONE with `word_cnt` = 0.
- Bad checksum (send 0x2A in the single-word case) → the word is still written, then `error` = 1 and `done` = 0. A following `start` and correct stream → `done` = 1 and `error` = 0.
- Drive `res` = 0 on the edge that accepts the 2nd data byte → no `im_we` occurs, state is IDLE, and every output is at its reset value. Restarting the load succeeds.

Source files
------------

// File: rtl/im_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | im_loader: byte-stream loader that fills instruction memory           |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module im_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h3000,
  parameter int          DEPTH     = 4096
) (
  input  logic        clk,
  input  logic        res,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic        in_ready,
  output logic        im_we,
  output logic [31:0] im_addr,
  output logic [31:0] im_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        error,
  output logic [12:0] word_cnt
);

  localparam logic [16:0] c_depth = 17'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LENH = 3'd1,
    S_LENL = 3'd2,
    S_DATA = 3'd3,
    S_CSUM = 3'd4,
    S_DONE = 3'd5,
    S_ERR  = 3'd6
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_len_hi;
  logic [15:0] r_len;
  logic [23:0] r_shift;
  logic [1:0]  r_idx;
  logic [7:0]  r_xor;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [12:0] r_word_cnt;

  logic [15:0] w_len;
  logic [12:0] w_cnt_inc;
  logic        w_last_word;

  assign w_len       = {r_len_hi, in_byte};
  assign w_cnt_inc   = r_word_cnt + 13'd1;
  assign w_last_word = ({3'd0, w_cnt_inc} == r_len);

  always_ff @(posedge clk) begin
    if (!res) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // in_ready depends on state only, so in_valid alone marks a transfer in
  // the four streaming states.
  always_comb begin
    w_next   = r_state;
    in_ready = 1'b0;
    cpu_hold = 1'b1;
    done     = 1'b0;
    error    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_LENH;
      end
      S_LENH: begin
        in_ready = 1'b1;
        if (in_valid) w_next = S_LENL;
      end
      S_LENL: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if ({1'b0, w_len} > c_depth) begin
            w_next = S_ERR;
          end else if (w_len == 16'd0) begin
            w_next = S_CSUM;
          end else begin
            w_next = S_DATA;
          end
        end
      end
      S_DATA: begin
        in_ready = 1'b1;
        if (in_valid && (r_idx == 2'd3) && w_last_word) w_next = S_CSUM;
      end
      S_CSUM: begin
        in_ready = 1'b1;
        if (in_valid) w_next = (in_byte == r_xor) ? S_DONE : S_ERR;
      end
      S_DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
        if (start) w_next = S_LENH;
      end
      S_ERR: begin
        error = 1'b1;
        if (start) w_next = S_LENH;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!res) begin
      r_len_hi   <= 8'd0;
      r_len      <= 16'd0;
      r_shift    <= 24'd0;
      r_idx      <= 2'd0;
      r_xor      <= 8'd0;
      r_we       <= 1'b0;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_word_cnt <= 13'd0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            r_word_cnt <= 13'd0;
            r_xor      <= 8'd0;
            r_idx      <= 2'd0;
          end
        end
        S_LENH: begin
          if (in_valid) r_len_hi <= in_byte;
        end
        S_LENL: begin
          if (in_valid) r_len <= w_len;
        end
        S_DATA: begin
          if (in_valid) begin
            r_xor <= r_xor ^ in_byte;
            r_idx <= r_idx + 2'd1;
            if (r_idx == 2'd3) begin
              r_we       <= 1'b1;
              r_wdata    <= {r_shift, in_byte};
              r_addr     <= BASE_ADDR + {17'd0, r_word_cnt, 2'b00};
              r_word_cnt <= w_cnt_inc;
            end else begin
              r_shift <= {r_shift[15:0], in_byte};
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign im_we    = r_we;
  assign im_addr  = r_addr;
  assign im_wdata = r_wdata;
  assign word_cnt = r_word_cnt;

endmodule
`default_nettype wire

// File: tb/tb_im_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_im_loader: scoreboard bench for im_loader                          |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_im_loader;

  logic        clk = 1'b0;
  logic        res;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_byte;
  logic        in_ready;
  logic        im_we;
  logic [31:0] im_addr;
  logic [31:0] im_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [12:0] word_cnt;

  im_loader dut (
    .clk      (clk),
    .res      (res),
    .start    (start),
    .in_valid (in_valid),
    .in_byte  (in_byte),
    .in_ready (in_ready),
    .im_we    (im_we),
    .im_addr  (im_addr),
    .im_wdata (im_wdata),
    .cpu_hold (cpu_hold),
    .done     (done),
    .error    (error),
    .word_cnt (word_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [12:0] cnt;
  } wr_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   stall_seen = 1'b0;
  wr_t  exp_q[$];
  int   we_cyc[$];
  wr_t  mon_e;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (im_we === 1'b1) begin
      we_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write", im_addr, im_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        chk("write_addr", im_addr, mon_e.addr);
        chk("write_data", im_wdata, mon_e.data);
        chk("write_cnt", {19'd0, word_cnt}, {19'd0, mon_e.cnt});
      end
    end
  end

  task automatic send(input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_byte  = b;
    while (in_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready %b expected 1", in_ready);
    end else begin
      if (n != 0) stall_seen = 1'b1;
      @(posedge clk); #1;
    end
  endtask

  task automatic put(input logic [7:0] b, input bit gap);
    send(b);
    if (gap) begin
      in_valid = 1'b0;
      in_byte  = 8'hEE;
      @(posedge clk); #1;
    end
  endtask

  task automatic start_pulse();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic stream(input logic [15:0] n, input logic [31:0] ws[$],
                        input logic [7:0] cs, input bit gap);
    put(n[15:8], gap);
    put(n[7:0], gap);
    foreach (ws[i]) begin
      for (int j = 0; j < 4; j++) begin
        if (j == 3)
          exp_q.push_back('{addr: 32'h3000 + 32'(4 * i), data: ws[i], cnt: 13'(i + 1)});
        put(ws[i][31 - 8 * j -: 8], gap);
      end
    end
    put(cs, 1'b0);
    in_valid = 1'b0;
  endtask

  task automatic chk_status(input string tag, input logic d, input logic e,
                            input logic h, input logic [12:0] wc);
    chk({tag, "_done"}, {31'd0, done}, {31'd0, d});
    chk({tag, "_error"}, {31'd0, error}, {31'd0, e});
    chk({tag, "_hold"}, {31'd0, cpu_hold}, {31'd0, h});
    chk({tag, "_wcnt"}, {19'd0, word_cnt}, {19'd0, wc});
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ready"}, {31'd0, in_ready}, 32'd0);
    chk({tag, "_we"}, {31'd0, im_we}, 32'd0);
    chk({tag, "_addr"}, im_addr, 32'd0);
    chk({tag, "_wdata"}, im_wdata, 32'd0);
    chk_status(tag, 1'b0, 1'b0, 1'b1, 13'd0);
  endtask

  logic [31:0] one_w[$];
  logic [31:0] three_w[$];
  logic [31:0] no_w[$];

  initial begin
    one_w   = '{32'h24080005};
    three_w = '{32'h11223344, 32'hA5A55A5A, 32'h01020304};
    no_w    = {};
    res = 1'b0; start = 1'b0; in_valid = 1'b0; in_byte = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk_reset("reset");
    res = 1'b1;
    @(posedge clk); #1;

    // Single word
    start_pulse();
    stream(16'd1, one_w, 8'h29, 1'b0);
    chk_status("single", 1'b1, 1'b0, 1'b0, 13'd1);

    // Three words back-to-back; checksum 0x40
    we_cyc.delete();
    stall_seen = 1'b0;
    start_pulse();
    chk_status("restart", 1'b0, 1'b0, 1'b1, 13'd0);
    stream(16'd3, three_w, 8'h40, 1'b0);
    @(posedge clk); #1;
    chk_status("b2b", 1'b1, 1'b0, 1'b0, 13'd3);
    chk("b2b_ready_steady", {31'd0, stall_seen}, 32'd0);
    chk("b2b_we_count", we_cyc.size(), 32'd3);
    if (we_cyc.size() == 3) begin
      chk("b2b_we_gap1", we_cyc[1] - we_cyc[0], 32'd4);
      chk("b2b_we_gap2", we_cyc[2] - we_cyc[1], 32'd4);
    end

    // Same stream with in_valid toggling
    we_cyc.delete();
    start_pulse();
    stream(16'd3, three_w, 8'h40, 1'b1);
    chk_status("gap", 1'b1, 1'b0, 1'b0, 13'd3);
    chk("gap_we_count", we_cyc.size(), 32'd3);
    if (we_cyc.size() == 3) begin
      chk("gap_we_gap1", we_cyc[1] - we_cyc[0], 32'd8);
      chk("gap_we_gap2", we_cyc[2] - we_cyc[1], 32'd8);
    end

    // Oversize length 4097
    start_pulse();
    send(8'h10);
    send(8'h01);
    in_valid = 1'b0;
    chk_status("oversize", 1'b0, 1'b1, 1'b1, 13'd0);
    chk("oversize_ready", {31'd0, in_ready}, 32'd0);
    repeat (3) @(posedge clk);
    #1;

    // Length 4096 is the largest accepted count
    start_pulse();
    send(8'h10);
    send(8'h00);
    in_valid = 1'b0;
    chk("maxlen_ready", {31'd0, in_ready}, 32'd1);
    chk("maxlen_error", {31'd0, error}, 32'd0);
    res = 1'b0;
    @(posedge clk); #1;
    res = 1'b1;

    // Zero length
    start_pulse();
    stream(16'd0, no_w, 8'h00, 1'b0);
    chk_status("zero", 1'b1, 1'b0, 1'b0, 13'd0);

    // Bad checksum, then a clean reload
    start_pulse();
    stream(16'd1, one_w, 8'h2A, 1'b0);
    chk_status("badsum", 1'b0, 1'b1, 1'b1, 13'd1);
    start_pulse();
    chk_status("badsum_restart", 1'b0, 1'b0, 1'b1, 13'd0);
    stream(16'd1, one_w, 8'h29, 1'b0);
    chk_status("reload", 1'b1, 1'b0, 1'b0, 13'd1);

    // Reset on the edge accepting the 2nd data byte
    start_pulse();
    send(8'h00); send(8'h01); send(8'h24);
    in_valid = 1'b1; in_byte = 8'h08; res = 1'b0;
    @(posedge clk); #1;
    chk_reset("midrst");
    res = 1'b1; in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("midrst_idle");

    // Reset on the edge presenting the 4th byte: no strobe may follow
    start_pulse();
    send(8'h00); send(8'h01); send(8'h24); send(8'h08); send(8'h00);
    in_valid = 1'b1; in_byte = 8'h05; res = 1'b0;
    @(posedge clk); #1;
    chk_reset("rst4");
    res = 1'b1; in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    start_pulse();
    stream(16'd1, one_w, 8'h29, 1'b0);
    chk_status("after_rst", 1'b1, 1'b0, 1'b0, 13'd1);

    @(posedge clk); #1;
    chk("pending_writes", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
